lcm_gcd_master: RTL and testbench
=================================

LCM_GCD_MASTER -- requirements
Module: lcm_gcd_master

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, operand width.
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles from issue to engine result.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_vld  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_rdy  output  1  upstream pair accepted when in_vld&&in_rdy.
REQ-007 SHALL have ports in_a, in_b  input  DATAWIDTH  operands.
REQ-008 SHALL have ports eng_a, eng_b  output  DATAWIDTH  operands driven to the lcm/gcd engine.
REQ-009 SHALL have port eng_en  output  1  engine request; accepted when eng_en&&eng_ready.
REQ-010 SHALL have port eng_ready  input  1  engine idle/accepting.
REQ-011 SHALL have port eng_vld  input  1  engine one-cycle result pulse.
REQ-012 SHALL have ports eng_gcd  input  DATAWIDTH, eng_lcm  input  2*DATAWIDTH  engine results.
REQ-013 SHALL have port out_vld  output  1  result valid; out_rdy  input  1  downstream accept.
REQ-014 SHALL have ports out_a, out_b  output  DATAWIDTH  echoed operands.
REQ-015 SHALL have ports out_gcd  output  DATAWIDTH, out_lcm  output  2*DATAWIDTH  results.
REQ-016 SHALL have ports out_err, out_tmo  output  1  result-check failure, engine timeout.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: in_rdy=1, all other handshake outputs 0; on in_vld, capture in_a/in_b; nonzero pair -> ISSUE, any zero operand -> RESP with gcd=0, lcm=0, err=1, tmo=0, no engine request.
REQ-019 ISSUE: eng_en=1, eng_a/eng_b hold captured operands stable; on eng_en&&eng_ready -> WAIT next cycle.
REQ-020 WAIT: eng_en=0; on eng_vld, capture eng_gcd/eng_lcm -> RESP.
REQ-021 Timeout counter SHALL clear on leaving IDLE, increment each cycle in ISSUE and WAIT; on reaching TIMEOUT without eng_vld -> RESP with tmo=1, err=0, gcd=0, lcm=0.
REQ-022 eng_vld in the same cycle the counter reaches TIMEOUT SHALL win (normal result, tmo=0).
REQ-023 Result check: err=1 if eng_gcd==0 or eng_gcd*eng_lcm != a*b, both products computed at full 3*DATAWIDTH / 2*DATAWIDTH width with no truncation; results are still forwarded.
REQ-024 RESP: out_vld=1 with all out_* held stable until out_vld&&out_rdy; then -> IDLE; in_rdy=0 throughout RESP.
REQ-025 Minimum latency: in accept to out_vld = 3 cycles plus engine latency (IDLE->ISSUE->WAIT->RESP); zero-operand path out_vld 1 cycle after accept.
REQ-026 eng_vld while in IDLE, ISSUE or RESP SHALL be ignored and SHALL not alter outputs.
REQ-027 One request outstanding at a time; no new upstream accept before the RESP handshake completes.

Reset
REQ-028 rstn low SHALL asynchronously force state IDLE, counter 0, and outputs: in_rdy=0 while rstn low then 1 in IDLE, eng_en=0, out_vld=0, out_err=0, out_tmo=0, all data outputs 0.
REQ-029 Reset mid-operation SHALL drop the in-flight request without producing out_vld; a late eng_vld after reset SHALL be ignored per REQ-026.

Structure
REQ-030 State encoding enum and width constants (DATAWIDTH-derived product widths) SHALL live in shared package lcm_gcd_pkg.
REQ-031 Result checker (products compare -> err) SHALL be a sub-module lcm_gcd_chk, purely combinational, instantiated once.

Verification
REQ-032 A=12,B=18, engine returns gcd=6,lcm=36 after 10 cycles -> out_gcd=6, out_lcm=36, err=0, tmo=0.
REQ-033 A=7,B=5 -> out_gcd=1, out_lcm=35; out_rdy low 5 cycles -> out_* stable, in_rdy=0 until accept.
REQ-034 A=0,B=9 -> no eng_en pulse, out_vld one cycle after accept, gcd=0, lcm=0, err=1.
REQ-035 A=12,B=18, engine returns gcd=4,lcm=36 -> out_err=1, out_gcd=4, out_lcm=36.
REQ-036 eng_vld never asserted, TIMEOUT=64 -> out_tmo=1 exactly 64 cycles after leaving IDLE; eng_vld on cycle 64 -> tmo=0.
REQ-037 rstn pulse during WAIT, then eng_vld -> no out_vld, in_rdy=1 in IDLE after reset release.

Source files
------------

// File: rtl/lcm_gcd_pkg.sv
// ============================================================================
// Module  : lcm_gcd_pkg
// Brief   : Shared FSM encoding and width helpers for the lcm/gcd master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lcm_gcd_pkg;

   localparam int DATAWIDTH_DEFAULT = 8;
   localparam int TIMEOUT_DEFAULT   = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // lcm result width: product of two operands
   function automatic int lcm_width(input int dw);
      return 2 * dw;
   endfunction

   // gcd*lcm product width used by the checker
   function automatic int chk_width(input int dw);
      return 3 * dw;
   endfunction

   // counter must be able to hold the value TIMEOUT itself
   function automatic int cnt_width(input int tmo);
      return $clog2(tmo + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcm_gcd_chk.sv
// ============================================================================
// Module  : lcm_gcd_chk
// Brief   : Combinational sanity check of an engine result: gcd*lcm == a*b.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lcm_gcd_chk
   import lcm_gcd_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
   input  logic [DATAWIDTH-1:0]            a,
   input  logic [DATAWIDTH-1:0]            b,
   input  logic [DATAWIDTH-1:0]            gcd,
   input  logic [lcm_width(DATAWIDTH)-1:0] lcm,
   output logic                            err
);

   localparam int LCM_W = lcm_width(DATAWIDTH);
   localparam int CHK_W = chk_width(DATAWIDTH);

   logic [CHK_W-1:0] w_gl;
   logic [LCM_W-1:0] w_ab;

   // both products at full width so a wrapped product can never alias a match
   assign w_gl = CHK_W'(gcd) * CHK_W'(lcm);
   assign w_ab = LCM_W'(a) * LCM_W'(b);
   assign err  = (gcd == '0) || (w_gl != CHK_W'(w_ab));

endmodule

`default_nettype wire

// File: rtl/lcm_gcd_master.sv
// ============================================================================
// Module  : lcm_gcd_master
// Brief   : Sequences one operand pair at a time through an lcm/gcd engine,
//           with result checking, zero-operand bypass and engine timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lcm_gcd_master
   import lcm_gcd_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
   parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
   input  logic                            clk,
   input  logic                            rstn,
   // upstream
   input  logic                            in_vld,
   output logic                            in_rdy,
   input  logic [DATAWIDTH-1:0]            in_a,
   input  logic [DATAWIDTH-1:0]            in_b,
   // engine
   output logic [DATAWIDTH-1:0]            eng_a,
   output logic [DATAWIDTH-1:0]            eng_b,
   output logic                            eng_en,
   input  logic                            eng_ready,
   input  logic                            eng_vld,
   input  logic [DATAWIDTH-1:0]            eng_gcd,
   input  logic [lcm_width(DATAWIDTH)-1:0] eng_lcm,
   // downstream
   output logic                            out_vld,
   input  logic                            out_rdy,
   output logic [DATAWIDTH-1:0]            out_a,
   output logic [DATAWIDTH-1:0]            out_b,
   output logic [DATAWIDTH-1:0]            out_gcd,
   output logic [lcm_width(DATAWIDTH)-1:0] out_lcm,
   output logic                            out_err,
   output logic                            out_tmo
);

   localparam int                LCM_W      = lcm_width(DATAWIDTH);
   localparam int                CNT_W      = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0]  C_TMO_LAST = CNT_W'(TIMEOUT - 1);

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [DATAWIDTH-1:0]   r_a;
   logic [DATAWIDTH-1:0]   r_b;
   logic                   r_in_rdy;
   logic                   r_eng_en;
   logic                   r_out_vld;
   logic [DATAWIDTH-1:0]   r_gcd;
   logic [LCM_W-1:0]       r_lcm;
   logic                   r_err;
   logic                   r_tmo;

   logic                   w_chk_err;
   logic                   w_tmo_hit;
   logic                   w_accept;
   logic                   w_zero_op;

   lcm_gcd_chk #(
      .DATAWIDTH (DATAWIDTH)
   ) u_chk (
      .a   (r_a),
      .b   (r_b),
      .gcd (eng_gcd),
      .lcm (eng_lcm),
      .err (w_chk_err)
   );

   // the edge that moves the count to TIMEOUT is the timeout edge
   assign w_tmo_hit = (r_cnt == C_TMO_LAST);
   assign w_accept  = in_vld && r_in_rdy;
   assign w_zero_op = (in_a == '0) || (in_b == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_in_rdy  <= 1'b0;
         r_eng_en  <= 1'b0;
         r_out_vld <= 1'b0;
         r_gcd     <= '0;
         r_lcm     <= '0;
         r_err     <= 1'b0;
         r_tmo     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_in_rdy <= 1'b1;
               if (w_accept) begin
                  r_a      <= in_a;
                  r_b      <= in_b;
                  r_cnt    <= '0;
                  r_in_rdy <= 1'b0;
                  r_gcd    <= '0;
                  r_lcm    <= '0;
                  r_tmo    <= 1'b0;
                  if (w_zero_op) begin
                     r_err     <= 1'b1;
                     r_out_vld <= 1'b1;
                     r_state   <= ST_RESP;
                  end else begin
                     r_err    <= 1'b0;
                     r_eng_en <= 1'b1;
                     r_state  <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_tmo_hit) begin
                  r_eng_en  <= 1'b0;
                  r_tmo     <= 1'b1;
                  r_out_vld <= 1'b1;
                  r_state   <= ST_RESP;
               end else if (eng_ready) begin
                  r_eng_en <= 1'b0;
                  r_state  <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // a result arriving on the timeout edge takes priority
               if (eng_vld) begin
                  r_gcd     <= eng_gcd;
                  r_lcm     <= eng_lcm;
                  r_err     <= w_chk_err;
                  r_out_vld <= 1'b1;
                  r_state   <= ST_RESP;
               end else if (w_tmo_hit) begin
                  r_tmo     <= 1'b1;
                  r_out_vld <= 1'b1;
                  r_state   <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (out_rdy) begin
                  r_out_vld <= 1'b0;
                  r_err     <= 1'b0;
                  r_tmo     <= 1'b0;
                  r_in_rdy  <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end

            default: begin
               r_eng_en  <= 1'b0;
               r_out_vld <= 1'b0;
               r_in_rdy  <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_rdy  = r_in_rdy;
   assign eng_en  = r_eng_en;
   assign eng_a   = r_a;
   assign eng_b   = r_b;
   assign out_vld = r_out_vld;
   assign out_a   = r_a;
   assign out_b   = r_b;
   assign out_gcd = r_gcd;
   assign out_lcm = r_lcm;
   assign out_err = r_err;
   assign out_tmo = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_lcm_gcd_master.sv
// ============================================================================
// Module  : tb_lcm_gcd_master
// Brief   : Self-checking bench for lcm_gcd_master with an engine stand-in.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcm_gcd_master;

   localparam int W   = 8;
   localparam int TMO = 64;

   logic          clk;
   logic          rstn;
   logic          in_vld, in_rdy;
   logic [W-1:0]  in_a, in_b;
   logic [W-1:0]  eng_a, eng_b;
   logic          eng_en, eng_ready, eng_vld;
   logic [W-1:0]  eng_gcd;
   logic [2*W-1:0] eng_lcm;
   logic          out_vld, out_rdy;
   logic [W-1:0]  out_a, out_b, out_gcd;
   logic [2*W-1:0] out_lcm;
   logic          out_err, out_tmo;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit             hung;
      bit             saw_en;
      bit             ops_bad;
      bit             stable;
      logic           rdy_start;
      logic           rdy_resp;
      logic           post_vld;
      logic           post_rdy;
      int             lat;
      logic [W-1:0]   a, b, g;
      logic [2*W-1:0] l;
      logic           err, tmo;
   } res_t;

   lcm_gcd_master #(.DATAWIDTH(W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rstn(rstn),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
      .eng_a(eng_a), .eng_b(eng_b), .eng_en(eng_en), .eng_ready(eng_ready),
      .eng_vld(eng_vld), .eng_gcd(eng_gcd), .eng_lcm(eng_lcm),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_a(out_a), .out_b(out_b),
      .out_gcd(out_gcd), .out_lcm(out_lcm), .out_err(out_err), .out_tmo(out_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference arithmetic
   function automatic int ref_gcd(input int a, input int b);
      int x = a, y = b, t;
      while (y != 0) begin t = x % y; x = y; y = t; end
      return x;
   endfunction

   function automatic bit ref_err(input longint a, input longint b, input longint g, input longint l);
      return (g == 0) || (g * l != a * b);
   endfunction

   // One transaction from a negedge with in_rdy expected high. e<0 means the
   // engine never answers; otherwise eng_vld comes e cycles into WAIT.
   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int dly, input int e,
                          input logic [W-1:0] g_ret, input logic [2*W-1:0] l_ret, input int hold,
                          input bit stray, output res_t r);
      int c = 0, vld_c = -1, en_cnt = 0;
      bit acc = 0;
      r.hung = 0; r.saw_en = 0; r.ops_bad = 0; r.stable = 1;
      r.rdy_start = in_rdy;
      in_a = a; in_b = b; in_vld = 1'b1; out_rdy = 1'b0;
      while (1) begin
         @(negedge clk); c++;
         in_vld    = 1'b0;
         eng_ready = 1'b0;
         eng_vld   = (c == vld_c);
         eng_gcd   = eng_vld ? g_ret : W'($urandom);
         eng_lcm   = eng_vld ? l_ret : (2*W)'($urandom);
         if (out_vld === 1'b1) break;
         if (c > 200) begin r.hung = 1; break; end
         if (eng_en === 1'b1 && !acc) begin
            r.saw_en = 1;
            if (eng_a !== a || eng_b !== b) r.ops_bad = 1;
            if (en_cnt >= dly) begin
               eng_ready = 1'b1; acc = 1;
               if (e >= 0) vld_c = c + 1 + e;
            end else if (stray) eng_vld = 1'b1;
            en_cnt++;
         end
      end
      r.lat = c; r.rdy_resp = in_rdy;
      r.a = out_a; r.b = out_b; r.g = out_gcd; r.l = out_lcm; r.err = out_err; r.tmo = out_tmo;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); eng_vld = 1'b0;
         if (out_vld !== 1'b1 || in_rdy !== 1'b0 || out_a !== r.a || out_b !== r.b || out_gcd !== r.g ||
             out_lcm !== r.l || out_err !== r.err || out_tmo !== r.tmo) r.stable = 0;
      end
      out_rdy = 1'b1;
      @(negedge clk);
      eng_vld = 1'b0; out_rdy = 1'b0;
      r.post_vld = out_vld; r.post_rdy = in_rdy;
   endtask

   task automatic test_reset();
      rstn = 1'b0; in_vld = 0; in_a = 0; in_b = 0; eng_ready = 0; eng_vld = 0;
      eng_gcd = 0; eng_lcm = 0; out_rdy = 0;
      repeat (3) @(negedge clk);
      total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL rst_in_rdy got=%b exp=0", in_rdy); end
      total++; if ({eng_en, out_vld, out_err, out_tmo} !== 4'b0) begin bad++;
         $display("FAIL rst_flags got=%b exp=0000", {eng_en, out_vld, out_err, out_tmo}); end
      total++; if ({eng_a, eng_b, out_a, out_b, out_gcd, out_lcm} !== '0) begin bad++;
         $display("FAIL rst_data got=%h exp=0", {eng_a, eng_b, out_a, out_b, out_gcd, out_lcm}); end
      rstn = 1'b1;
      @(negedge clk);
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL rst_idle_rdy got=%b exp=1", in_rdy); end
   endtask

   task automatic test_basic();
      res_t r;
      run_txn(12, 18, 0, 10, 6, 36, 0, 0, r);
      total++; if (r.hung || r.lat != 13) begin bad++; $display("FAIL basic_lat got=%0d hung=%0d exp=13", r.lat, r.hung); end
      total++; if (!r.saw_en || r.ops_bad) begin bad++; $display("FAIL basic_eng got en=%0d opsbad=%0d exp en=1 opsbad=0", r.saw_en, r.ops_bad); end
      total++; if (r.g !== 6 || r.l !== 36) begin bad++; $display("FAIL basic_res got=%0d/%0d exp=6/36", r.g, r.l); end
      total++; if (r.err !== 0 || r.tmo !== 0) begin bad++; $display("FAIL basic_flags got err=%b tmo=%b exp 0/0", r.err, r.tmo); end
      total++; if (r.a !== 12 || r.b !== 18) begin bad++; $display("FAIL basic_echo got=%0d/%0d exp=12/18", r.a, r.b); end
      total++; if (r.post_vld !== 0 || r.post_rdy !== 1) begin bad++; $display("FAIL basic_post got vld=%b rdy=%b exp 0/1", r.post_vld, r.post_rdy); end
   endtask

   task automatic test_backpressure();
      res_t r;
      run_txn(7, 5, 2, 3, 1, 35, 5, 1, r);
      total++; if (r.lat != 8) begin bad++; $display("FAIL bp_lat got=%0d exp=8", r.lat); end
      total++; if (r.g !== 1 || r.l !== 35 || r.err !== 0) begin bad++; $display("FAIL bp_res got=%0d/%0d err=%b exp=1/35 err=0", r.g, r.l, r.err); end
      total++; if (!r.stable || r.rdy_resp !== 0) begin bad++; $display("FAIL bp_hold got stable=%0d rdy=%b exp 1/0", r.stable, r.rdy_resp); end
      total++; if (r.post_vld !== 0 || r.post_rdy !== 1) begin bad++; $display("FAIL bp_post got vld=%b rdy=%b exp 0/1", r.post_vld, r.post_rdy); end
   endtask

   task automatic test_zero();
      res_t r;
      run_txn(0, 9, 0, 0, 3, 27, 1, 0, r);
      total++; if (r.saw_en || r.lat != 1) begin bad++; $display("FAIL zero_path got en=%0d lat=%0d exp en=0 lat=1", r.saw_en, r.lat); end
      total++; if (r.g !== 0 || r.l !== 0 || r.err !== 1 || r.tmo !== 0) begin bad++;
         $display("FAIL zero_res got=%0d/%0d err=%b tmo=%b exp=0/0 err=1 tmo=0", r.g, r.l, r.err, r.tmo); end
      run_txn(9, 0, 0, 0, 3, 27, 0, 0, r);
      total++; if (r.saw_en || r.lat != 1 || r.err !== 1) begin bad++; $display("FAIL zero_b got en=%0d lat=%0d err=%b exp 0/1/1", r.saw_en, r.lat, r.err); end
   endtask

   task automatic test_bad_result();
      res_t r;
      run_txn(12, 18, 0, 2, 4, 36, 0, 0, r);
      total++; if (r.err !== 1 || r.g !== 4 || r.l !== 36 || r.tmo !== 0) begin bad++;
         $display("FAIL badres got=%0d/%0d err=%b exp=4/36 err=1", r.g, r.l, r.err); end
      run_txn(3, 4, 0, 1, 0, 12, 0, 0, r);
      total++; if (r.err !== 1 || r.l !== 12) begin bad++; $display("FAIL badres_g0 got err=%b lcm=%0d exp 1/12", r.err, r.l); end
   endtask

   task automatic test_timeout();
      res_t r;
      run_txn(12, 18, 0, -1, 6, 36, 2, 0, r);
      total++; if (r.lat != TMO + 1 || r.tmo !== 1 || r.err !== 0) begin bad++;
         $display("FAIL tmo_none got lat=%0d tmo=%b err=%b exp lat=%0d tmo=1 err=0", r.lat, r.tmo, r.err, TMO + 1); end
      total++; if (r.g !== 0 || r.l !== 0 || !r.stable) begin bad++; $display("FAIL tmo_data got=%0d/%0d st=%0d exp=0/0 st=1", r.g, r.l, r.stable); end
      // result in the very cycle the count reaches TIMEOUT
      run_txn(12, 18, 0, TMO - 2, 6, 36, 0, 0, r);
      total++; if (r.lat != TMO + 1 || r.tmo !== 0 || r.g !== 6 || r.l !== 36) begin bad++;
         $display("FAIL tmo_edge got lat=%0d tmo=%b res=%0d/%0d exp lat=%0d tmo=0 6/36", r.lat, r.tmo, r.g, r.l, TMO + 1); end
      // one cycle too late: timeout, late pulse lands in RESP and must be ignored
      run_txn(12, 18, 0, TMO - 1, 6, 36, 2, 0, r);
      total++; if (r.tmo !== 1 || r.g !== 0 || !r.stable) begin bad++;
         $display("FAIL tmo_late got tmo=%b g=%0d st=%0d exp 1/0/1", r.tmo, r.g, r.stable); end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      in_a = 12; in_b = 18; in_vld = 1;
      @(negedge clk); in_vld = 0; eng_ready = 1;
      @(negedge clk); eng_ready = 0;
      repeat (2) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      total++; if ({in_rdy, eng_en, out_vld, out_err, out_tmo} !== 5'b0 || eng_a !== 0) begin bad++;
         $display("FAIL midrst_async got=%b eng_a=%0d exp=00000/0", {in_rdy, eng_en, out_vld, out_err, out_tmo}, eng_a); end
      @(negedge clk); rstn = 1'b1;
      eng_vld = 1; eng_gcd = 6; eng_lcm = 36;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); eng_vld = 0;
         if (out_vld !== 1'b0) seen = 1;
      end
      total++; if (seen) begin bad++; $display("FAIL midrst_vld got out_vld=1 exp=0"); end
      total++; if (in_rdy !== 1'b1 || out_gcd !== 0) begin bad++; $display("FAIL midrst_idle got rdy=%b gcd=%0d exp 1/0", in_rdy, out_gcd); end
   endtask

   task automatic test_random();
      res_t r;
      for (int n = 0; n < 24; n++) begin
         logic [W-1:0] a, b, g;
         logic [2*W-1:0] l;
         int dly, e, hold, gi;
         bit zero, xerr;
         a = W'($urandom_range(255)); b = W'($urandom_range(255));
         if ($urandom_range(7) == 0) a = 0;
         zero = (a == 0) || (b == 0);
         dly = $urandom_range(3); e = $urandom_range(8); hold = $urandom_range(2);
         gi = zero ? 0 : ref_gcd(int'(a), int'(b));
         g = W'(gi);
         l = zero ? '0 : (2*W)'((int'(a) * int'(b)) / (gi == 0 ? 1 : gi));
         case ($urandom_range(3))
            0: g = g ^ 8'h01;
            1: l = l + 16'd1;
            default: ;
         endcase
         xerr = zero ? 1'b1 : ref_err(longint'(a), longint'(b), longint'(g), longint'(l));
         run_txn(a, b, dly, e, g, l, hold, 1'($urandom_range(1)), r);
         total++;
         if (zero) begin
            if (r.lat != 1 || r.saw_en || r.g !== 0 || r.l !== 0 || r.err !== 1 || r.tmo !== 0) begin bad++;
               $display("FAIL rnd%0d_zero a=%0d b=%0d got lat=%0d en=%0d res=%0d/%0d err=%b", n, a, b, r.lat, r.saw_en, r.g, r.l, r.err); end
         end else begin
            if (r.lat != 3 + dly + e || r.ops_bad || r.g !== g || r.l !== l || r.err !== xerr || r.tmo !== 0) begin bad++;
               $display("FAIL rnd%0d a=%0d b=%0d got lat=%0d res=%0d/%0d err=%b exp lat=%0d res=%0d/%0d err=%b",
                        n, a, b, r.lat, r.g, r.l, r.err, 3 + dly + e, g, l, xerr); end
         end
         total++; if (!r.stable || r.rdy_resp !== 0 || r.post_vld !== 0 || r.post_rdy !== 1) begin bad++;
            $display("FAIL rnd%0d_hs got st=%0d rdy=%b pv=%b pr=%b exp 1/0/0/1", n, r.stable, r.rdy_resp, r.post_vld, r.post_rdy); end
      end
   endtask

   task automatic test_back_to_back();
      res_t r;
      for (int n = 1; n <= 4; n++) begin
         logic [W-1:0] a, b;
         a = W'(n * 6); b = W'(n * 4);
         run_txn(a, b, 0, 0, W'(n * 2), (2*W)'(n * 12), 0, 0, r);
         total++; if (r.rdy_start !== 1 || r.g !== W'(n * 2) || r.l !== (2*W)'(n * 12) || r.err !== 0 || r.lat != 3) begin bad++;
            $display("FAIL b2b%0d got rdy=%b res=%0d/%0d err=%b lat=%0d exp 1 %0d/%0d 0 3", n, r.rdy_start, r.g, r.l, r.err, r.lat, n * 2, n * 12); end
      end
   endtask

   task automatic test_idle_vld();
      @(negedge clk);
      eng_vld = 1; eng_gcd = 8'h55; eng_lcm = 16'h1234;
      @(negedge clk); eng_vld = 0;
      total++; if (out_vld !== 0 || in_rdy !== 1 || out_gcd === 8'h55) begin bad++;
         $display("FAIL idle_vld got vld=%b rdy=%b gcd=%0d exp 0/1/not 85", out_vld, in_rdy, out_gcd); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero();
      test_bad_result();
      test_idle_vld();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=expired exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
